iob_pcie_chnl_host: RTL and testbench
=====================================

Name: iob_pcie_chnl_host

Overview:
- Host-side endpoint of the PCIe channel interface, i.e. the opposite end to the iob_pcie peripheral.
- Drives the RX channel with length-prefixed 64-bit transactions sourced from a valid/ready stream.
- Accepts TX channel transactions and forwards their words to a valid/ready sink.
- Used as the bridge in the PCIe core wrapper and as the bus-functional partner in peripheral simulations.

Parameters:
- DATA_W, 32, width of length fields. The offset field is DATA_W-1 bits wide.
- C_PCI_DATA_WIDTH, 64, channel data word width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rx_start  in  1  one-cycle request to start an RX transaction; sampled only in R_IDLE
- rx_len  in  DATA_W  word count, sampled with rx_start
- rx_busy  out  1  high while an RX transaction is in progress
- src_data  in  C_PCI_DATA_WIDTH  RX payload source data
- src_valid  in  1  RX payload source valid
- src_ready  out  1  RX payload source ready
- PCIE_CHNL_RX  out  1  RX transaction active
- PCIE_CHNL_RX_ACK  in  1  peripheral acknowledges the RX transaction
- PCIE_CHNL_RX_LAST  out  1  constant 1
- PCIE_CHNL_RX_LEN  out  DATA_W  latched transaction length
- PCIE_CHNL_RX_OFF  out  DATA_W-1  constant 0
- PCIE_CHNL_RX_DATA  out  C_PCI_DATA_WIDTH  RX word
- PCIE_CHNL_RX_DATA_VALID  out  1  RX word valid
- PCIE_CHNL_RX_DATA_REN  in  1  peripheral read enable
- PCIE_CHNL_TX  in  1  TX transaction request from peripheral
- PCIE_CHNL_TX_ACK  out  1  one-cycle acknowledge
- PCIE_CHNL_TX_LAST  in  1  ignored
- PCIE_CHNL_TX_LEN  in  DATA_W  TX word count
- PCIE_CHNL_TX_OFF  in  DATA_W-1  ignored
- PCIE_CHNL_TX_DATA  in  C_PCI_DATA_WIDTH  TX word
- PCIE_CHNL_TX_DATA_VALID  in  1  TX word valid
- PCIE_CHNL_TX_DATA_REN  out  1  TX read enable
- snk_data  out  C_PCI_DATA_WIDTH  TX payload to sink
- snk_valid  out  1  TX payload valid
- snk_ready  in  1  TX payload sink ready
- tx_len_o  out  DATA_W  length of current/last TX transaction
- tx_done  out  1  one-cycle pulse when a TX transaction completes
- tx_err  out  1  one-cycle pulse when a TX transaction aborts

Behaviour:
- Reset (rst low, asynchronous): both FSMs go to IDLE. All registered outputs and counters are 0. Reset mid-transaction discards it with no done/err pulse.
- RX FSM, R_IDLE: rx_start=1 with rx_len!=0 latches PCIE_CHNL_RX_LEN and clears rx_cnt; next cycle goes to R_REQ. rx_start with rx_len==0 is ignored. rx_start outside R_IDLE is ignored.
- RX FSM, R_REQ: PCIE_CHNL_RX=1 and rx_busy=1. Waits for PCIE_CHNL_RX_ACK=1, then goes to R_DATA. An ACK already high on entry is accepted in the first R_REQ cycle.
- RX FSM, R_DATA: combinational pass-through. PCIE_CHNL_RX_DATA=src_data, PCIE_CHNL_RX_DATA_VALID=src_valid, src_ready=PCIE_CHNL_RX_DATA_REN.
  - A word transfers on VALID&REN; rx_cnt increments.
  - On the transfer where rx_cnt==PCIE_CHNL_RX_LEN-1, go to R_IDLE. PCIE_CHNL_RX and rx_busy drop the following cycle.
  - REN high before VALID is legal.
  - Outside R_DATA, PCIE_CHNL_RX_DATA_VALID=0 and src_ready=0.
- TX FSM, T_IDLE: on PCIE_CHNL_TX=1, latch tx_len_o=PCIE_CHNL_TX_LEN, clear tx_cnt, pulse PCIE_CHNL_TX_ACK for exactly one cycle (registered, one cycle after TX seen), then go to T_DATA. If the latched length is 0, go to T_DONE instead.
- TX FSM, T_DATA: PCIE_CHNL_TX_DATA_REN=snk_ready, snk_valid=PCIE_CHNL_TX_DATA_VALID, snk_data=PCIE_CHNL_TX_DATA.
  - A word transfers on VALID&REN; tx_cnt increments. VALID while REN is low is not counted; the sender holds or re-sends it.
  - The last transfer (tx_cnt==tx_len_o-1) goes to T_DONE.
  - PCIE_CHNL_TX falling while in T_DATA: pulse tx_err and go to T_IDLE.
- TX FSM, T_DONE: pulse tx_done on entry. REN=0. Wait for PCIE_CHNL_TX=0, then go to T_IDLE. This prevents re-acking the same request.
- Width rules: counters are DATA_W bits. Lengths up to 2^DATA_W-1 are supported with no wrap.
- Concurrency: RX and TX FSMs are independent and may run simultaneously.

Test Plan:
- rx_start, rx_len=3, src words 0x1..0x3 always valid, peripheral holds ACK=REN=1 -> PCIE_CHNL_RX high for 1 cycle + 3 transfers, exactly 3 words passed in order, rx_busy low after.
- rx_start, rx_len=0 -> PCIE_CHNL_RX stays 0, rx_busy stays 0.
- PCIE_CHNL_TX=1, LEN=4, four single-cycle VALID pulses with data 0xA0..0xA3, snk_ready=1 -> ACK one cycle, snk gets 0xA0..0xA3, tx_done one pulse, tx_len_o=4, no re-ack while TX stays high.
- TX LEN=2, snk_ready=0 for 5 cycles while VALID held, then 1 -> no word counted during stall, both words delivered, tx_done pulses once.
- TX LEN=5, PCIE_CHNL_TX dropped after 2 words -> tx_err pulse, FSM idle; a new TX request is acked normally.
- rst asserted low during RX word 2 of 4 and TX word 1 of 3 -> all outputs 0 immediately, no done/err pulses; a fresh rx_start after release runs correctly.

Source files
------------

// File: rtl/iob_pcie_chnl_host.sv
// Host-side PCIe channel endpoint: drives RX transactions from a stream
// and forwards TX transaction words to a sink.
module iob_pcie_chnl_host #(
    parameter int DATA_W           = 32,
    parameter int C_PCI_DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_start,
    input  logic [DATA_W-1:0]           rx_len,
    output logic                        rx_busy,
    input  logic [C_PCI_DATA_WIDTH-1:0] src_data,
    input  logic                        src_valid,
    output logic                        src_ready,
    output logic                        PCIE_CHNL_RX,
    input  logic                        PCIE_CHNL_RX_ACK,
    output logic                        PCIE_CHNL_RX_LAST,
    output logic [DATA_W-1:0]           PCIE_CHNL_RX_LEN,
    output logic [DATA_W-2:0]           PCIE_CHNL_RX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_RX_DATA,
    output logic                        PCIE_CHNL_RX_DATA_VALID,
    input  logic                        PCIE_CHNL_RX_DATA_REN,
    input  logic                        PCIE_CHNL_TX,
    output logic                        PCIE_CHNL_TX_ACK,
    input  logic                        PCIE_CHNL_TX_LAST,
    input  logic [DATA_W-1:0]           PCIE_CHNL_TX_LEN,
    input  logic [DATA_W-2:0]           PCIE_CHNL_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] PCIE_CHNL_TX_DATA,
    input  logic                        PCIE_CHNL_TX_DATA_VALID,
    output logic                        PCIE_CHNL_TX_DATA_REN,
    output logic [C_PCI_DATA_WIDTH-1:0] snk_data,
    output logic                        snk_valid,
    input  logic                        snk_ready,
    output logic [DATA_W-1:0]           tx_len_o,
    output logic                        tx_done,
    output logic                        tx_err
);

    localparam logic [DATA_W-1:0] ONE = 1;

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_DATA, T_DONE} tx_state_t;

    rx_state_t         rx_state, rx_state_n;
    logic [DATA_W-1:0] rx_len_q, rx_len_n;
    logic [DATA_W-1:0] rx_cnt, rx_cnt_n;

    tx_state_t         tx_state, tx_state_n;
    logic [DATA_W-1:0] tx_len_q, tx_len_n;
    logic [DATA_W-1:0] tx_cnt, tx_cnt_n;
    logic              tx_ack_q, tx_ack_n;
    logic              tx_done_q, tx_done_n;
    logic              tx_err_q, tx_err_n;

    logic rx_in_data, rx_xfer;
    logic tx_in_data, tx_xfer;
    logic unused_inputs;

    assign unused_inputs = ^{PCIE_CHNL_TX_LAST, PCIE_CHNL_TX_OFF};

    assign rx_in_data = (rx_state == R_DATA);
    assign rx_xfer    = rx_in_data & src_valid & PCIE_CHNL_RX_DATA_REN;
    assign tx_in_data = (tx_state == T_DATA);
    assign tx_xfer    = tx_in_data & PCIE_CHNL_TX_DATA_VALID & snk_ready;

    assign PCIE_CHNL_RX            = (rx_state != R_IDLE);
    assign rx_busy                 = (rx_state != R_IDLE);
    assign PCIE_CHNL_RX_LAST       = 1'b1;
    assign PCIE_CHNL_RX_OFF        = '0;
    assign PCIE_CHNL_RX_LEN        = rx_len_q;
    assign PCIE_CHNL_RX_DATA       = rx_in_data ? src_data : '0;
    assign PCIE_CHNL_RX_DATA_VALID = rx_in_data & src_valid;
    assign src_ready               = rx_in_data & PCIE_CHNL_RX_DATA_REN;

    assign PCIE_CHNL_TX_ACK      = tx_ack_q;
    assign PCIE_CHNL_TX_DATA_REN = tx_in_data & snk_ready;
    assign snk_valid             = tx_in_data & PCIE_CHNL_TX_DATA_VALID;
    assign snk_data              = tx_in_data ? PCIE_CHNL_TX_DATA : '0;
    assign tx_len_o              = tx_len_q;
    assign tx_done               = tx_done_q;
    assign tx_err                = tx_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state  <= R_IDLE;
            rx_len_q  <= '0;
            rx_cnt    <= '0;
            tx_state  <= T_IDLE;
            tx_len_q  <= '0;
            tx_cnt    <= '0;
            tx_ack_q  <= 1'b0;
            tx_done_q <= 1'b0;
            tx_err_q  <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_len_q  <= rx_len_n;
            rx_cnt    <= rx_cnt_n;
            tx_state  <= tx_state_n;
            tx_len_q  <= tx_len_n;
            tx_cnt    <= tx_cnt_n;
            tx_ack_q  <= tx_ack_n;
            tx_done_q <= tx_done_n;
            tx_err_q  <= tx_err_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_len_n   = rx_len_q;
        rx_cnt_n   = rx_cnt;
        unique case (rx_state)
            R_IDLE: begin
                if (rx_start && rx_len != '0) begin
                    rx_len_n   = rx_len;
                    rx_cnt_n   = '0;
                    rx_state_n = R_REQ;
                end
            end
            R_REQ: begin
                if (PCIE_CHNL_RX_ACK) rx_state_n = R_DATA;
            end
            R_DATA: begin
                if (rx_xfer) begin
                    rx_cnt_n = rx_cnt + ONE;
                    if (rx_cnt == rx_len_q - ONE) rx_state_n = R_IDLE;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_len_n   = tx_len_q;
        tx_cnt_n   = tx_cnt;
        tx_ack_n   = 1'b0;
        tx_done_n  = 1'b0;
        tx_err_n   = 1'b0;
        unique case (tx_state)
            T_IDLE: begin
                if (PCIE_CHNL_TX) begin
                    tx_len_n = PCIE_CHNL_TX_LEN;
                    tx_cnt_n = '0;
                    tx_ack_n = 1'b1;
                    if (PCIE_CHNL_TX_LEN == '0) begin
                        tx_state_n = T_DONE;
                        tx_done_n  = 1'b1;
                    end else begin
                        tx_state_n = T_DATA;
                    end
                end
            end
            T_DATA: begin
                // An aborted request wins over a word arriving the same cycle
                if (!PCIE_CHNL_TX) begin
                    tx_err_n   = 1'b1;
                    tx_state_n = T_IDLE;
                end else if (tx_xfer) begin
                    tx_cnt_n = tx_cnt + ONE;
                    if (tx_cnt == tx_len_q - ONE) begin
                        tx_state_n = T_DONE;
                        tx_done_n  = 1'b1;
                    end
                end
            end
            T_DONE: begin
                if (!PCIE_CHNL_TX) tx_state_n = T_IDLE;
            end
            default: tx_state_n = T_IDLE;
        endcase
    end

endmodule

// File: tb/tb_iob_pcie_chnl_host.sv
// Directed testbench for iob_pcie_chnl_host.
module tb_iob_pcie_chnl_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_start;
    logic [31:0] rx_len;
    logic        rx_busy;
    logic [63:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        rx;
    logic        rx_ack;
    logic        rx_last;
    logic [31:0] rx_len_out;
    logic [30:0] rx_off;
    logic [63:0] rx_data;
    logic        rx_data_valid;
    logic        rx_data_ren;
    logic        tx;
    logic        tx_ack;
    logic        tx_last;
    logic [31:0] tx_len;
    logic [30:0] tx_off;
    logic [63:0] tx_data;
    logic        tx_data_valid;
    logic        tx_data_ren;
    logic [63:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [31:0] tx_len_o;
    logic        tx_done;
    logic        tx_err;

    int errors = 0;
    int checks = 0;

    // bus monitors
    logic [63:0] rx_words[$];
    logic [63:0] snk_words[$];
    int rx_hi_cnt = 0;
    int ack_cnt   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    always #5 clk = ~clk;

    iob_pcie_chnl_host dut (
        .clk                     (clk),
        .rst                     (rst),
        .rx_start                (rx_start),
        .rx_len                  (rx_len),
        .rx_busy                 (rx_busy),
        .src_data                (src_data),
        .src_valid               (src_valid),
        .src_ready               (src_ready),
        .PCIE_CHNL_RX            (rx),
        .PCIE_CHNL_RX_ACK        (rx_ack),
        .PCIE_CHNL_RX_LAST       (rx_last),
        .PCIE_CHNL_RX_LEN        (rx_len_out),
        .PCIE_CHNL_RX_OFF        (rx_off),
        .PCIE_CHNL_RX_DATA       (rx_data),
        .PCIE_CHNL_RX_DATA_VALID (rx_data_valid),
        .PCIE_CHNL_RX_DATA_REN   (rx_data_ren),
        .PCIE_CHNL_TX            (tx),
        .PCIE_CHNL_TX_ACK        (tx_ack),
        .PCIE_CHNL_TX_LAST       (tx_last),
        .PCIE_CHNL_TX_LEN        (tx_len),
        .PCIE_CHNL_TX_OFF        (tx_off),
        .PCIE_CHNL_TX_DATA       (tx_data),
        .PCIE_CHNL_TX_DATA_VALID (tx_data_valid),
        .PCIE_CHNL_TX_DATA_REN   (tx_data_ren),
        .snk_data                (snk_data),
        .snk_valid               (snk_valid),
        .snk_ready               (snk_ready),
        .tx_len_o                (tx_len_o),
        .tx_done                 (tx_done),
        .tx_err                  (tx_err)
    );

    always @(posedge clk) begin
        if (rst) begin
            if (rx_data_valid && rx_data_ren) rx_words.push_back(rx_data);
            if (snk_valid && tx_data_ren) snk_words.push_back(snk_data);
            if (rx) rx_hi_cnt++;
            if (tx_ack) ack_cnt++;
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int a0, d0, e0, h0, n0;

    initial begin
        rst = 1'b0;
        rx_start = 0; rx_len = 0; src_data = 0; src_valid = 0;
        rx_ack = 0; rx_data_ren = 0;
        tx = 0; tx_last = 0; tx_len = 0; tx_off = 0;
        tx_data = 0; tx_data_valid = 0; snk_ready = 0;
        tick(); tick();
        chk("rst_rx", {63'd0, rx}, 64'd0);
        chk("rst_busy", {63'd0, rx_busy}, 64'd0);
        chk("rst_ack", {63'd0, tx_ack}, 64'd0);
        chk("rst_txlen", {32'd0, tx_len_o}, 64'd0);
        chk("rst_rxlen", {32'd0, rx_len_out}, 64'd0);
        chk("rx_last", {63'd0, rx_last}, 64'd1);
        chk("rx_off", {33'd0, rx_off}, 64'd0);
        rst = 1'b1;
        tick();

        // RX, 3 words, peripheral always ready
        h0 = rx_hi_cnt;
        rx_start = 1; rx_len = 3; rx_ack = 1; rx_data_ren = 1;
        src_valid = 1; src_data = 64'h1;
        tick();
        rx_start = 0;
        #1;
        chk("rx_req", {63'd0, rx}, 64'd1);
        chk("rx_req_busy", {63'd0, rx_busy}, 64'd1);
        chk("rx_len_latch", {32'd0, rx_len_out}, 64'd3);
        chk("rx_req_rdy", {63'd0, src_ready}, 64'd0);
        chk("rx_req_vld", {63'd0, rx_data_valid}, 64'd0);
        tick();
        chk("rx_d_vld", {63'd0, rx_data_valid}, 64'd1);
        chk("rx_d_data", rx_data, 64'h1);
        chk("rx_d_rdy", {63'd0, src_ready}, 64'd1);
        tick();
        src_data = 64'h2;
        tick();
        src_data = 64'h3;
        tick();
        src_valid = 0;
        #1;
        chk("rx_end_rx", {63'd0, rx}, 64'd0);
        chk("rx_end_busy", {63'd0, rx_busy}, 64'd0);
        chk("rx_nwords", 64'(rx_words.size()), 64'd3);
        if (rx_words.size() == 3) begin
            chk("rx_w0", rx_words[0], 64'h1);
            chk("rx_w1", rx_words[1], 64'h2);
            chk("rx_w2", rx_words[2], 64'h3);
        end
        chk("rx_hi_cycles", 64'(rx_hi_cnt - h0), 64'd4);

        // RX zero length is ignored
        rx_start = 1; rx_len = 0;
        tick();
        rx_start = 0;
        #1;
        chk("rx0_rx", {63'd0, rx}, 64'd0);
        chk("rx0_busy", {63'd0, rx_busy}, 64'd0);
        tick();
        chk("rx0_rx2", {63'd0, rx}, 64'd0);

        // TX, 4 words with single-cycle valid pulses
        a0 = ack_cnt; d0 = done_cnt; n0 = snk_words.size();
        tx = 1; tx_len = 4; snk_ready = 1;
        tick();
        chk("tx_ack_on", {63'd0, tx_ack}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            tx_data = 64'hA0 + 64'(i); tx_data_valid = 1;
            tick();
            if (i == 0) chk("tx_ack_off", {63'd0, tx_ack}, 64'd0);
            tx_data_valid = 0;
            tick();
        end
        for (int i = 0; i < 5; i++) tick();
        chk("tx_acks", 64'(ack_cnt - a0), 64'd1);
        chk("tx_dones", 64'(done_cnt - d0), 64'd1);
        chk("tx_len_o", {32'd0, tx_len_o}, 64'd4);
        chk("tx_nwords", 64'(snk_words.size() - n0), 64'd4);
        if (snk_words.size() == n0 + 4)
            for (int i = 0; i < 4; i++)
                chk("tx_word", snk_words[n0+i], 64'hA0 + 64'(i));
        chk("tx_done_ren", {63'd0, tx_data_ren}, 64'd0);
        tx = 0;
        tick(); tick();

        // TX, 2 words with a sink stall
        d0 = done_cnt; n0 = snk_words.size();
        tx = 1; tx_len = 2; snk_ready = 0;
        tick();
        tx_data = 64'hB0; tx_data_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_ren", {63'd0, tx_data_ren}, 64'd0);
        chk("stall_nwords", 64'(snk_words.size() - n0), 64'd0);
        snk_ready = 1;
        tick();
        tx_data = 64'hB1;
        tick();
        tx_data_valid = 0;
        tick();
        chk("stall_nwords2", 64'(snk_words.size() - n0), 64'd2);
        if (snk_words.size() == n0 + 2) begin
            chk("stall_w0", snk_words[n0], 64'hB0);
            chk("stall_w1", snk_words[n0+1], 64'hB1);
        end
        chk("stall_dones", 64'(done_cnt - d0), 64'd1);
        tx = 0;
        tick(); tick();

        // TX abort after 2 of 5 words, then a fresh request
        d0 = done_cnt; e0 = err_cnt;
        tx = 1; tx_len = 5;
        tick();
        tx_data = 64'hC0; tx_data_valid = 1;
        tick();
        tx_data = 64'hC1;
        tick();
        tx_data_valid = 0; tx = 0;
        tick();
        chk("abort_err", {63'd0, tx_err}, 64'd1);
        tick();
        chk("abort_err_off", {63'd0, tx_err}, 64'd0);
        chk("abort_dones", 64'(done_cnt - d0), 64'd0);
        tx = 1; tx_len = 1;
        tick();
        chk("reack", {63'd0, tx_ack}, 64'd1);
        chk("reack_len", {32'd0, tx_len_o}, 64'd1);
        tx_data = 64'hD0; tx_data_valid = 1;
        tick();
        chk("reack_done", {63'd0, tx_done}, 64'd1);
        tx_data_valid = 0; tx = 0;
        tick(); tick();
        chk("abort_errs", 64'(err_cnt - e0), 64'd1);

        // reset in the middle of RX and TX transactions
        rx_start = 1; rx_len = 4; rx_ack = 1; rx_data_ren = 1;
        tx = 1; tx_len = 3; snk_ready = 1;
        tick();
        rx_start = 0;
        tick();
        src_data = 64'h55; src_valid = 1;
        tx_data = 64'hE0; tx_data_valid = 1;
        tick();
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b0;
        #1;
        chk("mrst_rx", {63'd0, rx}, 64'd0);
        chk("mrst_busy", {63'd0, rx_busy}, 64'd0);
        chk("mrst_vld", {63'd0, rx_data_valid}, 64'd0);
        chk("mrst_rdy", {63'd0, src_ready}, 64'd0);
        chk("mrst_rxlen", {32'd0, rx_len_out}, 64'd0);
        chk("mrst_snkv", {63'd0, snk_valid}, 64'd0);
        chk("mrst_ren", {63'd0, tx_data_ren}, 64'd0);
        chk("mrst_txlen", {32'd0, tx_len_o}, 64'd0);
        chk("mrst_done", {63'd0, tx_done}, 64'd0);
        chk("mrst_err", {63'd0, tx_err}, 64'd0);
        src_valid = 0; tx_data_valid = 0; tx = 0;
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("mrst_dones", 64'(done_cnt - d0), 64'd0);
        chk("mrst_errs", 64'(err_cnt - e0), 64'd0);

        // fresh RX after reset
        n0 = rx_words.size();
        rx_start = 1; rx_len = 2; src_valid = 1; src_data = 64'h11;
        tick();
        rx_start = 0;
        tick();
        tick();
        src_data = 64'h12;
        tick();
        src_valid = 0;
        #1;
        chk("post_busy", {63'd0, rx_busy}, 64'd0);
        chk("post_nwords", 64'(rx_words.size() - n0), 64'd2);
        if (rx_words.size() == n0 + 2) begin
            chk("post_w0", rx_words[n0], 64'h11);
            chk("post_w1", rx_words[n0+1], 64'h12);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
